// File: rtl/datapath_core_param_if.sv
// Controller/ROM-facing bundle for datapath_core_param.
//   master : controller side; drives the source selects, load enables, ALU op,
//            fetch/branch controls and instruction memory read data.
//   slave  : datapath side; returns the instruction register, pc, bus, ALU result,
//            flags and the sticky bus-conflict flag.
interface datapath_core_param_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned IW    = 8,
  parameter int unsigned PC_W  = 9
);
  // Controller -> datapath
  logic [NREGS+2:0] rout;      // [i]=Ri, [NREGS]=G, [NREGS+1]=A, [NREGS+2]=EXTERN
  logic [NREGS+1:0] ren;       // [i]=Ri, [NREGS]=G, [NREGS+1]=A
  logic [1:0]       aluop;
  logic             fetch;
  logic             pc_load;
  logic [1:0]       pc_cond;
  logic [IW-1:0]    instr_in;

  // Datapath -> controller / ROM / debug
  logic [IW-1:0]    instruction;
  logic [PC_W-1:0]  pc;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu;
  logic             flag_z;
  logic             flag_c;
  logic             bus_error;

  modport master (
    output rout, ren, aluop, fetch, pc_load, pc_cond, instr_in,
    input  instruction, pc, bus, alu, flag_z, flag_c, bus_error
  );

  modport slave (
    input  rout, ren, aluop, fetch, pc_load, pc_cond, instr_in,
    output instruction, pc, bus, alu, flag_z, flag_c, bus_error
  );
endinterface

// File: rtl/datapath_core_param.sv
// Parametrised register/accumulator datapath with a shared multiplexed bus.
//   clk_i : rising-edge clock
//   rst_i : synchronous, active-high reset
//   dp    : slave side of datapath_core_param_if
//           inputs  rout/ren/aluop/fetch/pc_load/pc_cond/instr_in
//           outputs instruction/pc/bus/alu/flag_z/flag_c/bus_error
// Holds NREGS general registers, accumulator A and result register G, a four-op
// ALU (A op bus) with zero/carry flags captured on G loads, a program counter
// with conditional branch load, and the fetched instruction register.
module datapath_core_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned IW    = 8,
  parameter int unsigned IMM_W = 3,
  parameter int unsigned PC_W  = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  datapath_core_param_if.slave dp
);

  localparam int unsigned SelG   = NREGS;
  localparam int unsigned SelA   = NREGS + 1;
  localparam int unsigned SelExt = NREGS + 2;
  localparam int unsigned NSrc   = NREGS + 3;

  typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpXor = 2'b10, OpAnd = 2'b11} alu_op_e;
  typedef enum logic [1:0] {
    CondAlways = 2'b00, CondZ = 2'b01, CondNz = 2'b10, CondC = 2'b11
  } cond_e;

  // State
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IW-1:0]    instr_q, instr_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             err_q, err_d;

  // Combinational datapath
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu;
  logic             carry;
  logic             rout_any;
  logic             rout_multi;
  logic             cond_ok;
  logic             take;

  // Zero-extended immediate from the low instruction bits.
  always_comb begin
    imm = '0;
    imm[IMM_W-1:0] = instr_q[IMM_W-1:0];
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign rout_any   = |dp.rout;
  assign rout_multi = rout_any &&
                      ((dp.rout & (dp.rout - {{(NSrc-1){1'b0}}, 1'b1})) != '0);

  // Bus multiplexer; a conflicting select drives zero rather than a blend.
  always_comb begin
    bus = '0;
    if (!rout_multi) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (dp.rout[i]) bus = regs_q[i];
      end
      if (dp.rout[SelG])   bus = g_q;
      if (dp.rout[SelA])   bus = a_q;
      if (dp.rout[SelExt]) bus = imm;
    end
  end

  // ALU: A op bus. Add/sub run one bit wider so the top bit is carry/borrow.
  always_comb begin
    logic [WIDTH:0] ext;
    ext   = '0;
    alu   = '0;
    carry = 1'b0;
    unique case (alu_op_e'(dp.aluop))
      OpAdd: begin
        ext   = {1'b0, a_q} + {1'b0, bus};
        alu   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OpSub: begin
        ext   = {1'b0, a_q} - {1'b0, bus};
        alu   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OpXor: alu = a_q ^ bus;
      OpAnd: alu = a_q & bus;
      default: ;
    endcase
  end

  // Branch condition evaluated on the pre-edge flags.
  always_comb begin
    cond_ok = 1'b0;
    unique case (cond_e'(dp.pc_cond))
      CondAlways: cond_ok = 1'b1;
      CondZ:      cond_ok = z_q;
      CondNz:     cond_ok = !z_q;
      CondC:      cond_ok = c_q;
      default:    cond_ok = 1'b0;
    endcase
  end

  assign take = dp.pc_load && cond_ok;

  // Next-state logic
  always_comb begin
    regs_d  = regs_q;
    a_d     = a_q;
    g_d     = g_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    z_d     = z_q;
    c_d     = c_q;
    err_d   = err_q;

    for (int unsigned i = 0; i < NREGS; i++) begin
      if (dp.ren[i]) regs_d[i] = bus;
    end
    if (dp.ren[SelA]) a_d = bus;
    if (dp.ren[SelG]) begin
      g_d = alu;
      z_d = (alu == '0);
      c_d = carry;
    end

    if (dp.fetch) begin
      instr_d = dp.instr_in;
      pc_d    = pc_q + 1'b1;
    end
    // Taken branch overrides the sequential increment; upper bus bits are dropped.
    if (take) pc_d = bus[PC_W-1:0];

    if (rout_multi) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      a_q     <= '0;
      g_q     <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      a_q     <= a_d;
      g_q     <= g_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      z_q     <= z_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  assign dp.instruction = instr_q;
  assign dp.pc          = pc_q;
  assign dp.bus         = bus;
  assign dp.alu         = alu;
  assign dp.flag_z      = z_q;
  assign dp.flag_c      = c_q;
  assign dp.bus_error   = err_q;

endmodule

// File: tb/tb_datapath_core_param.sv
module tb_datapath_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst8;
  int   total = 0;
  int   bad   = 0;

  datapath_core_param_if #(.WIDTH(16), .NREGS(8), .IW(8), .PC_W(9)) dif ();
  datapath_core_param #(.WIDTH(16), .NREGS(8), .IW(8), .IMM_W(3), .PC_W(9)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .dp    (dif)
  );

  datapath_core_param_if #(.WIDTH(8), .NREGS(4), .IW(8), .PC_W(6)) dif8 ();
  datapath_core_param #(.WIDTH(8), .NREGS(4), .IW(8), .IMM_W(3), .PC_W(6)) dut8 (
    .clk_i (clk),
    .rst_i (rst8),
    .dp    (dif8)
  );

  // 16-bit instance selects / enables
  localparam logic [10:0] SR0 = 11'h001, SR1 = 11'h002, SR2 = 11'h004;
  localparam logic [10:0] SG  = 11'h100, SA  = 11'h200, SX  = 11'h400;
  localparam logic [9:0]  ER0 = 10'h001, ER1 = 10'h002, ER2 = 10'h004;
  localparam logic [9:0]  EG  = 10'h100, EA  = 10'h200;
  // 8-bit instance selects / enables
  localparam logic [6:0]  S8R1 = 7'h02, S8R3 = 7'h08, S8G = 7'h10, S8X = 7'h40;
  localparam logic [5:0]  E8R1 = 6'h02, E8R3 = 6'h08, E8G = 6'h10, E8A = 6'h20;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dif.rout = '0; dif.ren = '0; dif.aluop = 2'b00; dif.fetch = 1'b0;
    dif.pc_load = 1'b0; dif.pc_cond = 2'b00; dif.instr_in = '0;
  endtask

  task automatic idle8();
    dif8.rout = '0; dif8.ren = '0; dif8.aluop = 2'b00; dif8.fetch = 1'b0;
    dif8.pc_load = 1'b0; dif8.pc_cond = 2'b00; dif8.instr_in = '0;
  endtask

  task automatic op(input logic [10:0] r, input logic [9:0] e, input logic [1:0] a);
    idle(); dif.rout = r; dif.ren = e; dif.aluop = a; tick();
  endtask

  task automatic fetch_imm(input logic [7:0] ins);
    idle(); dif.instr_in = ins; dif.fetch = 1'b1; tick();
  endtask

  task automatic op8(input logic [6:0] r, input logic [5:0] e, input logic [1:0] a);
    idle8(); dif8.rout = r; dif8.ren = e; dif8.aluop = a; tick();
  endtask

  task automatic fetch8(input logic [7:0] ins);
    idle8(); dif8.instr_in = ins; dif8.fetch = 1'b1; tick();
  endtask

  // Builds an arbitrary value in A from 3-bit immediates by shift (doubling) and add.
  task automatic load_a(input logic [15:0] v);
    logic [17:0] vv;
    logic [2:0]  d;
    vv = {2'b00, v};
    op(11'h000, EA, 2'b00);
    for (int i = 5; i >= 0; i--) begin
      for (int j = 0; j < 3; j++) begin
        op(SA, EG, 2'b00);
        op(SG, EA, 2'b00);
      end
      d = vv[i*3 +: 3];
      if (d != 3'd0) begin
        fetch_imm({5'd0, d});
        op(SX, EG, 2'b00);
        op(SG, EA, 2'b00);
      end
    end
  endtask

  task automatic test_reset();
    fetch_imm(8'h45);
    op(SX, 10'h3FF, 2'b00);
    op(SR0 | SR1, 10'h000, 2'b00);
    idle();
    rst = 1'b1; dif.rout = SX; dif.ren = 10'h3FF; dif.fetch = 1'b1; dif.pc_load = 1'b1;
    dif.instr_in = 8'hFF;
    tick();
    rst = 1'b0; idle(); #1;
    total++; if (dif.pc !== 9'd0) begin bad++; $display("FAIL rst_pc got=%h want=0", dif.pc); end
    total++; if (dif.instruction !== 8'd0) begin
      bad++; $display("FAIL rst_instr got=%h want=0", dif.instruction); end
    total++; if (dif.flag_z !== 1'b0 || dif.flag_c !== 1'b0) begin
      bad++; $display("FAIL rst_flags got=%b%b want=00", dif.flag_z, dif.flag_c); end
    total++; if (dif.bus_error !== 1'b0) begin
      bad++; $display("FAIL rst_err got=%b want=0", dif.bus_error); end
    total++; if (dif.bus !== 16'd0) begin bad++; $display("FAIL rst_bus got=%h want=0", dif.bus); end
    for (int k = 0; k < 11; k++) begin
      dif.rout = 11'd1 << k; #1;
      total++; if (dif.bus !== 16'd0) begin
        bad++; $display("FAIL rst_src%0d got=%h want=0", k, dif.bus); end
    end
    idle();
  endtask

  task automatic test_imm();
    fetch_imm(8'b0100_0101);
    total++; if (dif.pc !== 9'd1) begin bad++; $display("FAIL imm_pc got=%h want=1", dif.pc); end
    total++; if (dif.instruction !== 8'h45) begin
      bad++; $display("FAIL imm_instr got=%h want=45", dif.instruction); end
    op(SX, ER0, 2'b00);
    idle(); dif.rout = SR0; #1;
    total++; if (dif.bus !== 16'h0005) begin bad++; $display("FAIL imm_r0 got=%h want=0005", dif.bus); end
  endtask

  task automatic test_arith();
    op(11'h000, EA, 2'b00);
    fetch_imm(8'd1);
    op(SX, ER1, 2'b00);
    op(SR1, EG, 2'b01);           // G = 0 - 1
    op(SG, EA, 2'b00);            // A = FFFF
    idle(); dif.rout = SR1; dif.ren = EG; dif.aluop = 2'b00; #1;
    total++; if (dif.alu !== 16'h0000) begin bad++; $display("FAIL add_alu got=%h want=0000", dif.alu); end
    tick();
    total++; if (dif.flag_z !== 1'b1 || dif.flag_c !== 1'b1) begin
      bad++; $display("FAIL add_flags zc got=%b%b want=11", dif.flag_z, dif.flag_c); end
    fetch_imm(8'd3);
    op(SX, EA, 2'b00);
    fetch_imm(8'd5);
    op(SX, ER1, 2'b00);
    op(SR1, EG, 2'b01);           // 3 - 5
    total++; if (dif.flag_z !== 1'b0 || dif.flag_c !== 1'b1) begin
      bad++; $display("FAIL sub_flags zc got=%b%b want=01", dif.flag_z, dif.flag_c); end
    idle(); dif.rout = SG; #1;
    total++; if (dif.bus !== 16'hFFFE) begin bad++; $display("FAIL sub_g got=%h want=FFFE", dif.bus); end
    op(SR1, EA, 2'b10);           // A load only; flags must hold
    total++; if (dif.flag_z !== 1'b0 || dif.flag_c !== 1'b1) begin
      bad++; $display("FAIL flag_hold zc got=%b%b want=01", dif.flag_z, dif.flag_c); end
  endtask

  task automatic test_branch();
    load_a(16'h0123);
    op(SA, ER2, 2'b00);
    op(SA, EG, 2'b10);            // A^A = 0 -> Z=1, C=0
    total++; if (dif.flag_z !== 1'b1) begin bad++; $display("FAIL br_setz got=%b want=1", dif.flag_z); end
    idle(); dif.rout = SR2; dif.pc_load = 1'b1; dif.pc_cond = 2'b01; dif.fetch = 1'b1;
    dif.instr_in = 8'hA7; tick();
    total++; if (dif.pc !== 9'h123) begin bad++; $display("FAIL br_z_pc got=%h want=123", dif.pc); end
    total++; if (dif.instruction !== 8'hA7) begin
      bad++; $display("FAIL br_z_instr got=%h want=A7", dif.instruction); end
    idle(); dif.rout = SR2; dif.pc_load = 1'b1; dif.pc_cond = 2'b10; dif.fetch = 1'b1;
    dif.instr_in = 8'h3C; tick();
    total++; if (dif.pc !== 9'h124) begin bad++; $display("FAIL br_nz_pc got=%h want=124", dif.pc); end
    total++; if (dif.instruction !== 8'h3C) begin
      bad++; $display("FAIL br_nz_instr got=%h want=3C", dif.instruction); end
    idle(); dif.rout = SR2; dif.pc_load = 1'b1; dif.pc_cond = 2'b11; tick();
    total++; if (dif.pc !== 9'h124) begin bad++; $display("FAIL br_c_pc got=%h want=124", dif.pc); end
    // G load in the branch cycle: branch sees old Z=1, G gets 0x246 so Z falls.
    idle(); dif.rout = SR2; dif.ren = EG; dif.aluop = 2'b00; dif.pc_load = 1'b1;
    dif.pc_cond = 2'b01; tick();
    total++; if (dif.pc !== 9'h123) begin bad++; $display("FAIL br_oldflag_pc got=%h want=123", dif.pc); end
    total++; if (dif.flag_z !== 1'b0) begin
      bad++; $display("FAIL br_oldflag_z got=%b want=0", dif.flag_z); end
    idle(); dif.rout = SG; dif.pc_load = 1'b1; dif.pc_cond = 2'b01; tick();
    total++; if (dif.pc !== 9'h123) begin bad++; $display("FAIL br_nt_pc got=%h want=123", dif.pc); end
    idle(); dif.rout = SG; dif.pc_load = 1'b1; dif.pc_cond = 2'b10; tick();
    total++; if (dif.pc !== 9'h046) begin bad++; $display("FAIL br_trunc_pc got=%h want=046", dif.pc); end
  endtask

  task automatic test_wrap();
    load_a(16'h03FF);
    idle(); dif.rout = SA; dif.pc_load = 1'b1; dif.pc_cond = 2'b00; tick();
    total++; if (dif.pc !== 9'h1FF) begin bad++; $display("FAIL wrap_set got=%h want=1FF", dif.pc); end
    fetch_imm(8'h11);
    total++; if (dif.pc !== 9'h000) begin bad++; $display("FAIL wrap_pc got=%h want=000", dif.pc); end
  endtask

  task automatic test_conflict();
    idle(); dif.rout = SR0 | SR1; #1;
    total++; if (dif.bus !== 16'd0) begin bad++; $display("FAIL cf_bus got=%h want=0", dif.bus); end
    total++; if (dif.bus_error !== 1'b0) begin
      bad++; $display("FAIL cf_pre got=%b want=0", dif.bus_error); end
    tick();
    idle(); #1;
    total++; if (dif.bus_error !== 1'b1) begin
      bad++; $display("FAIL cf_set got=%b want=1", dif.bus_error); end
    repeat (3) tick();
    total++; if (dif.bus_error !== 1'b1) begin
      bad++; $display("FAIL cf_sticky got=%b want=1", dif.bus_error); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (dif.bus_error !== 1'b0) begin
      bad++; $display("FAIL cf_clear got=%b want=0", dif.bus_error); end
  endtask

  // Random single-source traffic against a register-level behavioural model.
  task automatic test_random();
    logic [15:0] m_r [8];
    logic [15:0] m_a, m_g, eb, ealu;
    logic [8:0]  m_pc;
    logic [7:0]  m_ins;
    logic        m_z, m_c, m_err, ec, ok;
    int unsigned s, k;
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_a = '0; m_g = '0; m_pc = '0; m_ins = '0; m_z = 0; m_c = 0; m_err = 0;
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 11);
      dif.rout     = (k == 11) ? 11'd0 : (11'd1 << k);
      dif.ren      = 10'($urandom);
      dif.aluop    = 2'($urandom);
      dif.fetch    = 1'($urandom);
      dif.pc_load  = 1'($urandom);
      dif.pc_cond  = 2'($urandom);
      dif.instr_in = 8'($urandom);
      #1;
      eb = '0;
      if (k < 8) eb = m_r[k];
      else if (k == 8) eb = m_g;
      else if (k == 9) eb = m_a;
      else if (k == 10) eb = {13'd0, m_ins[2:0]};
      ec = 1'b0;
      case (dif.aluop)
        2'b00: begin s = m_a + eb; ealu = s[15:0]; ec = (s > 32'hFFFF); end
        2'b01: begin ealu = m_a - eb; ec = (m_a < eb); end
        2'b10: ealu = m_a ^ eb;
        default: ealu = m_a & eb;
      endcase
      total++; if (dif.bus !== eb) begin
        bad++; $display("FAIL rnd_bus[%0d] got=%h want=%h", n, dif.bus, eb); end
      total++; if (dif.alu !== ealu) begin
        bad++; $display("FAIL rnd_alu[%0d] got=%h want=%h", n, dif.alu, ealu); end
      case (dif.pc_cond)
        2'b00: ok = 1'b1;
        2'b01: ok = m_z;
        2'b10: ok = !m_z;
        default: ok = m_c;
      endcase
      if (dif.pc_load && ok) m_pc = eb[8:0];
      else if (dif.fetch) m_pc = 9'((m_pc + 1) % 512);
      if (dif.fetch) m_ins = dif.instr_in;
      for (int i = 0; i < 8; i++) if (dif.ren[i]) m_r[i] = eb;
      if (dif.ren[9]) m_a = eb;
      if (dif.ren[8]) begin m_g = ealu; m_z = (ealu == 16'd0); m_c = ec; end
      tick();
      total++; if (dif.pc !== m_pc) begin
        bad++; $display("FAIL rnd_pc[%0d] got=%h want=%h", n, dif.pc, m_pc); end
      total++; if (dif.instruction !== m_ins) begin
        bad++; $display("FAIL rnd_instr[%0d] got=%h want=%h", n, dif.instruction, m_ins); end
      total++; if (dif.flag_z !== m_z || dif.flag_c !== m_c) begin
        bad++; $display("FAIL rnd_flags[%0d] got=%b%b want=%b%b", n, dif.flag_z, dif.flag_c,
                        m_z, m_c); end
      total++; if (dif.bus_error !== m_err) begin
        bad++; $display("FAIL rnd_err[%0d] got=%b want=%b", n, dif.bus_error, m_err); end
    end
    idle();
  endtask

  task automatic test_param8();
    idle8(); rst8 = 1'b1; tick(); rst8 = 1'b0;
    op8(7'h00, E8A, 2'b00);
    fetch8(8'd1);
    op8(S8X, E8R1, 2'b00);
    op8(S8R1, E8G, 2'b01);        // G = 0 - 1 = FF
    total++; if (dif8.flag_c !== 1'b1 || dif8.flag_z !== 1'b0) begin
      bad++; $display("FAIL p8_borrow zc got=%b%b want=01", dif8.flag_z, dif8.flag_c); end
    op8(S8G, E8A, 2'b00);
    idle8(); dif8.rout = S8R1; dif8.ren = E8G; dif8.aluop = 2'b00; #1;
    total++; if (dif8.alu !== 8'h00) begin bad++; $display("FAIL p8_add_alu got=%h want=00", dif8.alu); end
    tick();
    total++; if (dif8.flag_z !== 1'b1 || dif8.flag_c !== 1'b1) begin
      bad++; $display("FAIL p8_add_flags zc got=%b%b want=11", dif8.flag_z, dif8.flag_c); end
    fetch8(8'd3);
    op8(S8X, E8A, 2'b00);
    fetch8(8'd5);
    op8(S8X, E8R1, 2'b00);
    op8(S8R1, E8G, 2'b01);
    total++; if (dif8.flag_z !== 1'b0 || dif8.flag_c !== 1'b1) begin
      bad++; $display("FAIL p8_sub_flags zc got=%b%b want=01", dif8.flag_z, dif8.flag_c); end
    idle8(); dif8.rout = S8G; #1;
    total++; if (dif8.bus !== 8'hFE) begin bad++; $display("FAIL p8_sub_g got=%h want=FE", dif8.bus); end
    fetch8(8'd6);
    op8(S8X, E8R3, 2'b00);
    idle8(); dif8.rout = S8R3; #1;
    total++; if (dif8.bus !== 8'h06) begin bad++; $display("FAIL p8_r3 got=%h want=06", dif8.bus); end
    total++; if (dif8.pc !== 6'd4) begin bad++; $display("FAIL p8_pc got=%h want=04", dif8.pc); end
    idle8();
  endtask

  initial begin
    rst = 1'b1; rst8 = 1'b1;
    idle(); idle8();
    repeat (2) tick();
    rst = 1'b0; rst8 = 1'b0;
    test_reset();
    test_imm();
    test_arith();
    test_branch();
    test_wrap();
    test_conflict();
    test_random();
    test_param8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
